multicycle_control_unit: RTL and testbench

- Registered, handshaked control unit for the pocket-calculator CPU.
- Takes one decoded instruction at a time from fetch and drives one cycle of datapath control strobes.
- Runs multi-cycle ALU ops (FACT) through a start/done handshake with the ALU.
- Generalised in opcode width, general-register count and stack-select width; register selects are a one-hot vector.

---
 rtl/multicycle_control_unit.sv | 398 +++++++++++++++++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
// Registered, handshaked control unit for the pocket-calculator CPU. Accepts
// one decoded instruction at a time and drives one cycle of datapath strobes.
// FACT is run through a start/done handshake with the multi-cycle ALU.
//
// Optional build macro: CU_MC_TIMEOUT_EN
//   When defined, MC_WAIT is bounded by MC_TIMEOUT cycles; on expiry the unit
//   returns to IDLE, pulses timeout_o and skips the writeback. When undefined
//   the unit waits for mc_done_i indefinitely and timeout_o is tied low.
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter int OPCODE_W   = 6,
    parameter int REG_SEL_W  = 1,
    parameter int STK_SEL_W  = 2,
    parameter int MC_TIMEOUT = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      instr_valid_i,
    output logic                      instr_ready_o,
    input  logic [OPCODE_W-1:0]       opcode_i,
    input  logic [REG_SEL_W-1:0]      register_address_i,
    input  logic [STK_SEL_W-1:0]      register_address_stack_i,
    input  logic [3:0]                flags_i,
    input  logic                      mc_done_i,
    output logic                      mc_start_o,
    output logic                      alu_o,
    output logic                      bra_o,
    output logic                      bra_taken_o,
    output logic                      load_o,
    output logic                      store_o,
    output logic                      copy_o,
    output logic                      push_o,
    output logic                      pop_o,
    output logic                      mov_o,
    output logic                      sel_flag_o,
    output logic                      sel_acc_o,
    output logic                      sel_pc_o,
    output logic [(2**REG_SEL_W)-1:0] sel_reg_o,
    output logic                      busy_o,
    output logic                      illegal_o,
    output logic                      timeout_o
);

    localparam int NREG = 2 ** REG_SEL_W;

    // Opcode encodings, zero-extended to the configured opcode width.
    localparam logic [OPCODE_W-1:0] OP_BRZ    = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_BRN    = OPCODE_W'(6'b000001);
    localparam logic [OPCODE_W-1:0] OP_BRC    = OPCODE_W'(6'b000010);
    localparam logic [OPCODE_W-1:0] OP_BRO    = OPCODE_W'(6'b000011);
    localparam logic [OPCODE_W-1:0] OP_BRA    = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_NOT    = OPCODE_W'(6'b010011);
    localparam logic [OPCODE_W-1:0] OP_CMP    = OPCODE_W'(6'b010100);
    localparam logic [OPCODE_W-1:0] OP_INC    = OPCODE_W'(6'b010110);
    localparam logic [OPCODE_W-1:0] OP_DEC    = OPCODE_W'(6'b010111);
    localparam logic [OPCODE_W-1:0] OP_FACT   = OPCODE_W'(6'b011000);
    localparam logic [OPCODE_W-1:0] OP_MOV    = OPCODE_W'(6'b011001);
    localparam logic [OPCODE_W-1:0] OP_LOAD   = OPCODE_W'(6'b011010);
    localparam logic [OPCODE_W-1:0] OP_STORE  = OPCODE_W'(6'b011011);
    localparam logic [OPCODE_W-1:0] OP_COPY_X = OPCODE_W'(6'b011100);
    localparam logic [OPCODE_W-1:0] OP_COPY_Y = OPCODE_W'(6'b011101);
    localparam logic [OPCODE_W-1:0] OP_PUSH   = OPCODE_W'(6'b011110);
    localparam logic [OPCODE_W-1:0] OP_POP    = OPCODE_W'(6'b011111);

    // Fixed register selects used by COPY_X / COPY_Y.
    localparam logic [NREG-1:0] COPY_X_SEL = NREG'(1);
    localparam logic [NREG-1:0] COPY_Y_SEL = NREG'(1) << (1 % NREG);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_EXEC     = 3'd1,
        S_MC_START = 3'd2,
        S_MC_WAIT  = 3'd3,
        S_MC_WB    = 3'd4
    } state_t;

    state_t                 state_q;
    logic [REG_SEL_W-1:0]   ra_q;

    logic                   instr_ready_q;
    logic                   busy_q;
    logic                   mc_start_q;
    logic                   alu_q;
    logic                   bra_q;
    logic                   bra_taken_q;
    logic                   load_q;
    logic                   store_q;
    logic                   copy_q;
    logic                   push_q;
    logic                   pop_q;
    logic                   mov_q;
    logic                   sel_flag_q;
    logic                   sel_acc_q;
    logic                   sel_pc_q;
    logic [NREG-1:0]        sel_reg_q;
    logic                   illegal_q;
    logic                   timeout_q;

    // Decoded strobes for the instruction presented on the inputs; these are
    // what EXEC will show if the instruction is accepted on this edge.
    logic                   dec_alu_d;
    logic                   dec_bra_d;
    logic                   dec_bra_taken_d;
    logic                   dec_load_d;
    logic                   dec_store_d;
    logic                   dec_copy_d;
    logic                   dec_push_d;
    logic                   dec_pop_d;
    logic                   dec_mov_d;
    logic                   dec_sel_flag_d;
    logic                   dec_sel_acc_d;
    logic                   dec_sel_pc_d;
    logic [NREG-1:0]        dec_sel_reg_d;
    logic                   dec_illegal_d;
    logic                   dec_fact_d;

    logic [NREG-1:0]        ra_onehot;
    logic [NREG-1:0]        wb_onehot;
    logic [NREG-1:0]        stk_onehot;
    logic [31:0]            stk_ext;
    logic                   stk_is_acc;
    logic                   stk_is_pc;
    logic                   stk_legal;

    assign stk_ext    = 32'(register_address_stack_i);
    assign stk_is_acc = (stk_ext == 32'(NREG));
    assign stk_is_pc  = (stk_ext == 32'(NREG + 1));
    assign stk_legal  = (stk_ext <= 32'(NREG + 1));

    // One-hot register selects: operand field, captured writeback target and
    // stack code (stack codes at or above NREG leave stk_onehot all-zero).
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_sel
            assign ra_onehot[gi]  = (register_address_i == REG_SEL_W'(gi));
            assign wb_onehot[gi]  = (ra_q == REG_SEL_W'(gi));
            assign stk_onehot[gi] = (stk_ext == 32'(gi));
        end
    endgenerate

    // Instruction decode table; anything not listed is flagged illegal.
    always_comb begin
        dec_alu_d       = 1'b0;
        dec_bra_d       = 1'b0;
        dec_bra_taken_d = 1'b0;
        dec_load_d      = 1'b0;
        dec_store_d     = 1'b0;
        dec_copy_d      = 1'b0;
        dec_push_d      = 1'b0;
        dec_pop_d       = 1'b0;
        dec_mov_d       = 1'b0;
        dec_sel_flag_d  = 1'b0;
        dec_sel_acc_d   = 1'b0;
        dec_sel_pc_d    = 1'b0;
        dec_sel_reg_d   = '0;
        dec_illegal_d   = 1'b0;
        dec_fact_d      = 1'b0;
        case (opcode_i)
            // flags_i is {O,C,N,Z}
            OP_BRZ: begin
                dec_bra_d       = 1'b1;
                dec_bra_taken_d = flags_i[0];
            end
            OP_BRN: begin
                dec_bra_d       = 1'b1;
                dec_bra_taken_d = flags_i[1];
            end
            OP_BRC: begin
                dec_bra_d       = 1'b1;
                dec_bra_taken_d = flags_i[2];
            end
            OP_BRO: begin
                dec_bra_d       = 1'b1;
                dec_bra_taken_d = flags_i[3];
            end
            OP_BRA: begin
                dec_bra_d       = 1'b1;
                dec_bra_taken_d = 1'b1;
            end
            OP_CMP: begin
                dec_alu_d      = 1'b1;
                dec_sel_flag_d = 1'b1;
            end
            OP_INC, OP_DEC, OP_NOT: begin
                dec_alu_d      = 1'b1;
                dec_sel_flag_d = 1'b1;
                dec_sel_reg_d  = ra_onehot;
            end
            OP_LOAD: begin
                dec_load_d    = 1'b1;
                dec_sel_reg_d = ra_onehot;
            end
            OP_STORE: begin
                dec_store_d   = 1'b1;
                dec_sel_reg_d = ra_onehot;
            end
            OP_MOV: begin
                dec_mov_d     = 1'b1;
                dec_sel_reg_d = ra_onehot;
            end
            OP_COPY_X: begin
                dec_copy_d    = 1'b1;
                dec_sel_reg_d = COPY_X_SEL;
            end
            OP_COPY_Y: begin
                dec_copy_d    = 1'b1;
                dec_sel_reg_d = COPY_Y_SEL;
            end
            OP_PUSH: begin
                if (stk_legal) begin
                    dec_push_d    = 1'b1;
                    dec_store_d   = 1'b1;
                    dec_sel_reg_d = stk_onehot;
                    dec_sel_acc_d = stk_is_acc;
                    dec_sel_pc_d  = stk_is_pc;
                end else begin
                    dec_illegal_d = 1'b1;
                end
            end
            OP_POP: begin
                if (stk_legal) begin
                    dec_pop_d     = 1'b1;
                    dec_load_d    = 1'b1;
                    dec_sel_reg_d = stk_onehot;
                    dec_sel_acc_d = stk_is_acc;
                    dec_sel_pc_d  = stk_is_pc;
                end else begin
                    dec_illegal_d = 1'b1;
                end
            end
            OP_FACT: begin
                dec_fact_d = 1'b1;
            end
            default: begin
                dec_illegal_d = 1'b1;
            end
        endcase
    end

`ifdef CU_MC_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(MC_TIMEOUT + 1);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);
    // Count value seen in the last permitted MC_WAIT cycle.
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'((MC_TIMEOUT > 0) ? (MC_TIMEOUT - 1) : 0);

    logic [CNT_W-1:0] cnt_q;
`endif

    // Main FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= S_IDLE;
            ra_q          <= '0;
            instr_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            mc_start_q    <= 1'b0;
            alu_q         <= 1'b0;
            bra_q         <= 1'b0;
            bra_taken_q   <= 1'b0;
            load_q        <= 1'b0;
            store_q       <= 1'b0;
            copy_q        <= 1'b0;
            push_q        <= 1'b0;
            pop_q         <= 1'b0;
            mov_q         <= 1'b0;
            sel_flag_q    <= 1'b0;
            sel_acc_q     <= 1'b0;
            sel_pc_q      <= 1'b0;
            sel_reg_q     <= '0;
            illegal_q     <= 1'b0;
            timeout_q     <= 1'b0;
`ifdef CU_MC_TIMEOUT_EN
            cnt_q         <= '0;
`endif
        end else begin
            // Strobes and pulses are one cycle wide unless a state sets them.
            mc_start_q  <= 1'b0;
            alu_q       <= 1'b0;
            bra_q       <= 1'b0;
            bra_taken_q <= 1'b0;
            load_q      <= 1'b0;
            store_q     <= 1'b0;
            copy_q      <= 1'b0;
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            mov_q       <= 1'b0;
            sel_flag_q  <= 1'b0;
            sel_acc_q   <= 1'b0;
            sel_pc_q    <= 1'b0;
            sel_reg_q   <= '0;
            illegal_q   <= 1'b0;
            timeout_q   <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (instr_valid_i) begin
                        ra_q          <= register_address_i;
                        instr_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                        if (dec_fact_d) begin
                            state_q    <= S_MC_START;
                            mc_start_q <= 1'b1;
                            alu_q      <= 1'b1;
                            sel_flag_q <= 1'b1;
                        end else begin
                            state_q     <= S_EXEC;
                            alu_q       <= dec_alu_d;
                            bra_q       <= dec_bra_d;
                            bra_taken_q <= dec_bra_taken_d;
                            load_q      <= dec_load_d;
                            store_q     <= dec_store_d;
                            copy_q      <= dec_copy_d;
                            push_q      <= dec_push_d;
                            pop_q       <= dec_pop_d;
                            mov_q       <= dec_mov_d;
                            sel_flag_q  <= dec_sel_flag_d;
                            sel_acc_q   <= dec_sel_acc_d;
                            sel_pc_q    <= dec_sel_pc_d;
                            sel_reg_q   <= dec_sel_reg_d;
                            illegal_q   <= dec_illegal_d;
                        end
                    end
                end

                S_EXEC: begin
                    state_q       <= S_IDLE;
                    instr_ready_q <= 1'b1;
                    busy_q        <= 1'b0;
                end

                S_MC_START: begin
                    // A done pulse coincident with the start cycle skips MC_WAIT.
                    if (mc_done_i) begin
                        state_q   <= S_MC_WB;
                        sel_reg_q <= wb_onehot;
                    end else begin
                        state_q <= S_MC_WAIT;
`ifdef CU_MC_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end

                S_MC_WAIT: begin
                    // Done has priority over an expiring count.
                    if (mc_done_i) begin
                        state_q   <= S_MC_WB;
                        sel_reg_q <= wb_onehot;
`ifdef CU_MC_TIMEOUT_EN
                    end else if (cnt_q >= CNT_TERM) begin
                        state_q       <= S_IDLE;
                        timeout_q     <= 1'b1;
                        instr_ready_q <= 1'b1;
                        busy_q        <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
`endif
                    end
                end

                S_MC_WB: begin
                    state_q       <= S_IDLE;
                    instr_ready_q <= 1'b1;
                    busy_q        <= 1'b0;
                end

                default: begin
                    state_q       <= S_IDLE;
                    instr_ready_q <= 1'b1;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    // Ready is held low while reset is applied and rises the moment it is
    // released (the register itself resets to 1).
    assign instr_ready_o = instr_ready_q & rst_n_i;
    assign busy_o        = busy_q;
    assign mc_start_o    = mc_start_q;
    assign alu_o         = alu_q;
    assign bra_o         = bra_q;
    assign bra_taken_o   = bra_taken_q;
    assign load_o        = load_q;
    assign store_o       = store_q;
    assign copy_o        = copy_q;
    assign push_o        = push_q;
    assign pop_o         = pop_q;
    assign mov_o         = mov_q;
    assign sel_flag_o    = sel_flag_q;
    assign sel_acc_o     = sel_acc_q;
    assign sel_pc_o      = sel_pc_q;
    assign sel_reg_o     = sel_reg_q;
    assign illegal_o     = illegal_q;
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
// Directed self-checking bench for multicycle_control_unit (REG_SEL_W = 1,
// STK_SEL_W = 2, MC_TIMEOUT = 4). The timeout scenarios run only when the
// design is built with CU_MC_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [5:0] opcode = '0;
    logic [0:0] ra = '0;
    logic [1:0] stk = '0;
    logic [3:0] flags = '0;
    logic       mc_done = 1'b0;
    logic       mc_start, alu, bra, bra_taken, load, store, copy, push, pop, mov;
    logic       sel_flag, sel_acc, sel_pc, busy, illegal, timeout;
    logic [1:0] sel_reg;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_control_unit #(
        .OPCODE_W   (6),
        .REG_SEL_W  (1),
        .STK_SEL_W  (2),
        .MC_TIMEOUT (4)
    ) dut (
        .clk_i                    (clk),
        .rst_n_i                  (rst_n),
        .instr_valid_i            (instr_valid),
        .instr_ready_o            (instr_ready),
        .opcode_i                 (opcode),
        .register_address_i       (ra),
        .register_address_stack_i (stk),
        .flags_i                  (flags),
        .mc_done_i                (mc_done),
        .mc_start_o               (mc_start),
        .alu_o                    (alu),
        .bra_o                    (bra),
        .bra_taken_o              (bra_taken),
        .load_o                   (load),
        .store_o                  (store),
        .copy_o                   (copy),
        .push_o                   (push),
        .pop_o                    (pop),
        .mov_o                    (mov),
        .sel_flag_o               (sel_flag),
        .sel_acc_o                (sel_acc),
        .sel_pc_o                 (sel_pc),
        .sel_reg_o                (sel_reg),
        .busy_o                   (busy),
        .illegal_o                (illegal),
        .timeout_o                (timeout)
    );

    always #5 clk = ~clk;

    // Packed view of every strobe/pulse output.
    logic [16:0] obs;
    assign obs = {alu, bra, bra_taken, load, store, copy, push, pop, mov,
                  sel_flag, sel_acc, sel_pc, sel_reg, mc_start, illegal, timeout};

    localparam logic [16:0] M_NONE  = 17'd0;
    localparam logic [16:0] M_ALU   = 17'd1 << 16;
    localparam logic [16:0] M_BRA   = 17'd1 << 15;
    localparam logic [16:0] M_TAKEN = 17'd1 << 14;
    localparam logic [16:0] M_LOAD  = 17'd1 << 13;
    localparam logic [16:0] M_STORE = 17'd1 << 12;
    localparam logic [16:0] M_COPY  = 17'd1 << 11;
    localparam logic [16:0] M_PUSH  = 17'd1 << 10;
    localparam logic [16:0] M_POP   = 17'd1 << 9;
    localparam logic [16:0] M_MOV   = 17'd1 << 8;
    localparam logic [16:0] M_SELF  = 17'd1 << 7;
    localparam logic [16:0] M_ACC   = 17'd1 << 6;
    localparam logic [16:0] M_PC    = 17'd1 << 5;
    localparam logic [16:0] M_REG1  = 17'd1 << 4;
    localparam logic [16:0] M_REG0  = 17'd1 << 3;
    localparam logic [16:0] M_MCST  = 17'd1 << 2;
    localparam logic [16:0] M_ILL   = 17'd1 << 1;
    localparam logic [16:0] M_TOUT  = 17'd1 << 0;

    typedef struct {
        logic [5:0]  op;
        logic [0:0]  ra;
        logic [1:0]  stk;
        logic [3:0]  flags;
        logic [16:0] exp;
    } vec_t;

    vec_t vecs [19];

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction for one edge (the unit must be in IDLE).
    task automatic accept(input logic [5:0] o, input logic [0:0] r,
                          input logic [1:0] s, input logic [3:0] f);
        opcode      = o;
        ra          = r;
        stk         = s;
        flags       = f;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if (obs !== M_NONE) begin
            n_err++;
            $display("FAIL reset_strobes got=%h want=%h", obs, M_NONE);
        end
        n_cmp++;
        if (instr_ready !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready_busy got ready=%b busy=%b want ready=0 busy=0", instr_ready, busy);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (instr_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL release_ready_busy got ready=%b busy=%b want ready=1 busy=0", instr_ready, busy);
        end
        tick();
        n_cmp++;
        if (instr_ready !== 1'b1 || busy !== 1'b0 || obs !== M_NONE) begin
            n_err++;
            $display("FAIL idle_after_reset got ready=%b busy=%b obs=%h want 1 0 %h", instr_ready, busy, obs, M_NONE);
        end
    endtask

    task automatic test_single_ops();
        vecs[0]  = '{6'b010110, 1'b1, 2'd0, 4'b0000, M_ALU | M_SELF | M_REG1};  // INC r1
        vecs[1]  = '{6'b000000, 1'b0, 2'd0, 4'b0001, M_BRA | M_TAKEN};          // BRZ Z=1
        vecs[2]  = '{6'b000001, 1'b0, 2'd0, 4'b0001, M_BRA};                    // BRN N=0
        vecs[3]  = '{6'b000010, 1'b0, 2'd0, 4'b0100, M_BRA | M_TAKEN};          // BRC C=1
        vecs[4]  = '{6'b000011, 1'b0, 2'd0, 4'b0111, M_BRA};                    // BRO O=0
        vecs[5]  = '{6'b000100, 1'b0, 2'd0, 4'b0000, M_BRA | M_TAKEN};          // BRA
        vecs[6]  = '{6'b010100, 1'b1, 2'd0, 4'b0000, M_ALU | M_SELF};           // CMP
        vecs[7]  = '{6'b010111, 1'b0, 2'd0, 4'b0000, M_ALU | M_SELF | M_REG0};  // DEC r0
        vecs[8]  = '{6'b010011, 1'b1, 2'd0, 4'b0000, M_ALU | M_SELF | M_REG1};  // NOT r1
        vecs[9]  = '{6'b011010, 1'b0, 2'd0, 4'b0000, M_LOAD | M_REG0};          // LOAD r0
        vecs[10] = '{6'b011011, 1'b1, 2'd0, 4'b0000, M_STORE | M_REG1};         // STORE r1
        vecs[11] = '{6'b011001, 1'b1, 2'd0, 4'b0000, M_MOV | M_REG1};           // MOV r1
        vecs[12] = '{6'b011100, 1'b1, 2'd0, 4'b0000, M_COPY | M_REG0};          // COPY_X
        vecs[13] = '{6'b011101, 1'b0, 2'd0, 4'b0000, M_COPY | M_REG1};          // COPY_Y
        vecs[14] = '{6'b011110, 1'b1, 2'd0, 4'b0000, M_PUSH | M_STORE | M_REG0}; // PUSH k=0
        vecs[15] = '{6'b011110, 1'b0, 2'd1, 4'b0000, M_PUSH | M_STORE | M_REG1}; // PUSH k=1
        vecs[16] = '{6'b011110, 1'b0, 2'd2, 4'b0000, M_PUSH | M_STORE | M_ACC};  // PUSH k=2
        vecs[17] = '{6'b011111, 1'b0, 2'd3, 4'b0000, M_POP | M_LOAD | M_PC};     // POP k=3
        vecs[18] = '{6'b111111, 1'b1, 2'd2, 4'b1111, M_ILL};                     // undefined
        for (int i = 0; i < 19; i++) begin
            accept(vecs[i].op, vecs[i].ra, vecs[i].stk, vecs[i].flags);
            n_cmp++;
            if (obs !== vecs[i].exp) begin
                n_err++;
                $display("FAIL exec_strobes[%0d] op=%b got=%h want=%h", i, vecs[i].op, obs, vecs[i].exp);
            end
            n_cmp++;
            if (instr_ready !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL exec_handshake[%0d] got ready=%b busy=%b want ready=0 busy=1", i, instr_ready, busy);
            end
            tick();
            n_cmp++;
            if (obs !== M_NONE || instr_ready !== 1'b1 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL exec_return[%0d] got obs=%h ready=%b busy=%b want obs=0 ready=1 busy=0", i, obs, instr_ready, busy);
            end
            $display("single op %0d opcode=%b ra=%0d stk=%0d flags=%b obs=%h", i, vecs[i].op, vecs[i].ra, vecs[i].stk, vecs[i].flags, obs);
        end
    endtask

    task automatic test_back_to_back();
        // valid held high: the second instruction must wait for IDLE.
        opcode = 6'b010110; ra = 1'b0; instr_valid = 1'b1;
        tick();
        n_cmp++;
        if (obs !== (M_ALU | M_SELF | M_REG0)) begin
            n_err++;
            $display("FAIL b2b_first got=%h want=%h", obs, M_ALU | M_SELF | M_REG0);
        end
        opcode = 6'b011010; ra = 1'b1;
        tick();
        n_cmp++;
        if (obs !== M_NONE || instr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_gap got obs=%h ready=%b want obs=0 ready=1", obs, instr_ready);
        end
        tick();
        instr_valid = 1'b0;
        n_cmp++;
        if (obs !== (M_LOAD | M_REG1)) begin
            n_err++;
            $display("FAIL b2b_second got=%h want=%h", obs, M_LOAD | M_REG1);
        end
        tick();
        $display("back-to-back INC r0 then LOAD r1 done");
    endtask

    task automatic test_fact();
        accept(6'b011000, 1'b0, 2'd0, 4'b0000);
        n_cmp++;
        if (obs !== (M_MCST | M_ALU | M_SELF) || busy !== 1'b1) begin
            n_err++;
            $display("FAIL fact_start got obs=%h busy=%b want obs=%h busy=1", obs, busy, M_MCST | M_ALU | M_SELF);
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_cmp++;
            if (obs !== M_NONE || busy !== 1'b1 || instr_ready !== 1'b0) begin
                n_err++;
                $display("FAIL fact_wait[%0d] got obs=%h busy=%b ready=%b want 0 1 0", i, obs, busy, instr_ready);
            end
        end
        mc_done = 1'b1;   // sampled on the 5th edge after MC_START
        tick();
        mc_done = 1'b0;
        n_cmp++;
        if (obs !== M_REG0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL fact_wb got obs=%h busy=%b want obs=%h busy=1", obs, busy, M_REG0);
        end
        tick();
        n_cmp++;
        if (obs !== M_NONE || busy !== 1'b0 || instr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL fact_idle got obs=%h busy=%b ready=%b want 0 0 1", obs, busy, instr_ready);
        end
        $display("FACT r0 with done after 5 cycles complete");
    endtask

    task automatic test_fact_fast();
        accept(6'b011000, 1'b1, 2'd0, 4'b0000);
        mc_done = 1'b1;   // done during MC_START_S
        tick();
        mc_done = 1'b0;
        n_cmp++;
        if (obs !== M_REG1) begin
            n_err++;
            $display("FAIL fact_fast_wb got=%h want=%h", obs, M_REG1);
        end
        tick();
        n_cmp++;
        if (obs !== M_NONE || instr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL fact_fast_idle got obs=%h ready=%b want obs=0 ready=1", obs, instr_ready);
        end
        // A done pulse while idle must not cause a writeback.
        mc_done = 1'b1;
        tick();
        mc_done = 1'b0;
        n_cmp++;
        if (obs !== M_NONE || busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_done_ignored got obs=%h busy=%b want obs=0 busy=0", obs, busy);
        end
        $display("FACT r1 with done in start cycle complete");
    endtask

    task automatic test_reset_mid_fact();
        accept(6'b011000, 1'b1, 2'd0, 4'b0000);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== M_NONE || busy !== 1'b0 || instr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_outputs got obs=%h busy=%b ready=%b want 0 0 0", obs, busy, instr_ready);
        end
        #1;
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (instr_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_release got ready=%b busy=%b want ready=1 busy=0", instr_ready, busy);
        end
        mc_done = 1'b1;
        tick();
        mc_done = 1'b0;
        n_cmp++;
        if (obs !== M_NONE || busy !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_no_wb got obs=%h busy=%b want obs=0 busy=0", obs, busy);
        end
        $display("reset during FACT wait complete");
    endtask

`ifdef CU_MC_TIMEOUT_EN
    task automatic test_timeout();
        accept(6'b011000, 1'b1, 2'd0, 4'b0000);
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_cmp++;
            if (obs !== M_NONE || busy !== 1'b1) begin
                n_err++;
                $display("FAIL tout_wait[%0d] got obs=%h busy=%b want obs=0 busy=1", i, obs, busy);
            end
        end
        tick();
        n_cmp++;
        if (obs !== M_TOUT || instr_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL tout_pulse got obs=%h ready=%b busy=%b want obs=%h 1 0", obs, instr_ready, busy, M_TOUT);
        end
        tick();
        n_cmp++;
        if (obs !== M_NONE) begin
            n_err++;
            $display("FAIL tout_after got=%h want=0", obs);
        end
        // Done on the terminal-count cycle wins over the timeout.
        accept(6'b011000, 1'b0, 2'd0, 4'b0000);
        for (int i = 1; i <= 4; i++) tick();
        mc_done = 1'b1;
        tick();
        mc_done = 1'b0;
        n_cmp++;
        if (obs !== M_REG0) begin
            n_err++;
            $display("FAIL tout_done_wins got=%h want=%h", obs, M_REG0);
        end
        tick();
        $display("FACT timeout scenarios complete");
    endtask
`endif

    initial begin
        test_reset();
        test_single_ops();
        test_back_to_back();
        test_fact();
        test_fact_fast();
        test_reset_mid_fact();
`ifdef CU_MC_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
